// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port, plus the
// per-register pending scoreboard that decode uses for RAW hazard checks.

module wb_sb_bit (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic set_i,
  input  logic clr_i,
  output logic pend_o
);
  // A set beats a clear on the same edge: the set belongs to the newer producer.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) pend_o <= 1'b0;
    else if (set_i)       pend_o <= 1'b1;
    else if (clr_i)       pend_o <= 1'b0;
  end
endmodule

module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*5-1:0]      req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      we_o,
  output logic [4:0]                waddr_o,
  output logic [DATA_W-1:0]         wdata_o,
  input  logic                      set_valid_i,
  input  logic [4:0]                set_addr_i,
  input  logic                      flush_i,
  input  logic [4:0]                raddr_a_i,
  input  logic [4:0]                raddr_b_i,
  output logic                      busy_a_o,
  output logic                      busy_b_o
);
  localparam int RR_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic              we;
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } wb_t;

  logic [RR_W-1:0]    rr, rr_nxt;
  logic [NUM_REQ-1:0] grant;
  logic               acc;
  logic [4:0]         sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic [31:0]        pending;
  wb_t                wb_q;

  // Round-robin search starting at rr; the first valid source wins.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    acc      = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    rr_nxt   = rr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr) + i) % NUM_REQ;
      if (!acc && !rst_i && req_valid_i[idx]) begin
        acc        = 1'b1;
        grant[idx] = 1'b1;
        sel_addr   = req_addr_i[idx*5 +: 5];
        sel_data   = req_data_i[idx*DATA_W +: DATA_W];
        rr_nxt     = (idx == NUM_REQ-1) ? '0 : RR_W'(idx + 1);
      end
    end
  end

  assign req_ready_o = grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr   <= '0;
      wb_q <= '0;
    end else begin
      rr <= rr_nxt;
      if (acc) wb_q <= '{we: (sel_addr != 5'd0), addr: sel_addr, data: sel_data};
      else     wb_q.we <= 1'b0;
    end
  end

  assign we_o    = wb_q.we;
  assign waddr_o = wb_q.addr;
  assign wdata_o = wb_q.data;

  // x0 is never pending, so bit 0 has no storage.
  assign pending[0] = 1'b0;
  for (genvar r = 1; r < 32; r++) begin : g_sb
    wb_sb_bit u_bit (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .flush_i(flush_i),
      .set_i  (set_valid_i && (set_addr_i == 5'(r))),
      .clr_i  (acc && (sel_addr == 5'(r))),
      .pend_o (pending[r])
    );
  end

  assign busy_a_o = !rst_i && pending[raddr_a_i];
  assign busy_b_o = !rst_i && pending[raddr_b_i];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter with a queue of expected
// write-port states; reset-mid-operation is a hand-written sequence.

module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        set_valid;
  logic [4:0]  set_addr;
  logic        flush;
  logic [4:0]  raddr_a, raddr_b;
  logic        busy_a, busy_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
    .set_valid_i(set_valid), .set_addr_i(set_addr), .flush_i(flush),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .busy_a_o(busy_a), .busy_b_o(busy_b)
  );

  typedef struct packed {
    logic [2:0]        valid;
    logic [2:0][4:0]   addr;
    logic [2:0][31:0]  data;
    logic              sv;
    logic [4:0]        sa;
    logic              fl;
    logic [4:0]        ra;
    logic [4:0]        rb;
    logic [2:0]        exp_rdy;
    logic              exp_ba;
    logic              exp_bb;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t m_out;
  vec_t vecs[19];

  function automatic vec_t mk(logic [2:0] valid, logic [14:0] addr, logic [95:0] data,
                              logic sv, logic [4:0] sa, logic fl, logic [4:0] ra,
                              logic [4:0] rb, logic [2:0] er, logic eba, logic ebb);
    vec_t v;
    v.valid = valid; v.addr = addr; v.data = data;
    v.sv = sv; v.sa = sa; v.fl = fl; v.ra = ra; v.rb = rb;
    v.exp_rdy = er; v.exp_ba = eba; v.exp_bb = ebb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid = v.valid; req_addr = v.addr; req_data = v.data;
    set_valid = v.sv; set_addr = v.sa; flush = v.fl;
    raddr_a = v.ra; raddr_b = v.rb;
  endtask

  // Called at posedge+1: drive, check combinational outputs at the negedge,
  // push the expected write-port state at the edge, compare it just after.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    drive(v);
    #4;
    chk({tag, " ready"}, 64'(req_ready), 64'(v.exp_rdy));
    chk({tag, " busy_a"}, 64'(busy_a), 64'(v.exp_ba));
    chk({tag, " busy_b"}, 64'(busy_b), 64'(v.exp_bb));
    @(posedge clk);
    m_out.we = 1'b0;
    for (int g = 0; g < 3; g++)
      if (v.exp_rdy[g]) m_out = '{we: (v.addr[g] != 5'd0), addr: v.addr[g], data: v.data[g]};
    sbq.push_back(m_out);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, " queue"}, 64'(0), 64'(1));
    end else begin
      e = sbq.pop_front();
      chk({tag, " we"}, 64'(we), 64'(e.we));
      chk({tag, " waddr"}, 64'(waddr), 64'(e.addr));
      chk({tag, " wdata"}, 64'(wdata), 64'(e.data));
    end
  endtask

  localparam logic [14:0] A567 = {5'd7, 5'd6, 5'd5};
  localparam logic [95:0] DABC = {32'hC, 32'hB, 32'hA};

  initial begin
    // all three sources, continuously valid: rotate 0,1,2 twice
    vecs[0]  = mk(3'b111, A567, DABC, 0, 0, 0, 0, 0, 3'b001, 0, 0);
    vecs[1]  = mk(3'b111, A567, DABC, 0, 0, 0, 0, 0, 3'b010, 0, 0);
    vecs[2]  = mk(3'b111, A567, DABC, 0, 0, 0, 0, 0, 3'b100, 0, 0);
    vecs[3]  = mk(3'b111, A567, DABC, 0, 0, 0, 0, 0, 3'b001, 0, 0);
    vecs[4]  = mk(3'b111, A567, DABC, 0, 0, 0, 0, 0, 3'b010, 0, 0);
    vecs[5]  = mk(3'b111, A567, DABC, 0, 0, 0, 0, 0, 3'b100, 0, 0);
    // LSU only with rr=0, then ALU write to x0
    vecs[6]  = mk(3'b010, {5'd0, 5'd3, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 0, 0, 0, 0, 0, 3'b010, 0, 0);
    vecs[7]  = mk(3'b001, 15'd0, {64'h0, 32'h1234}, 0, 0, 0, 0, 0, 3'b001, 0, 0);
    // x9 pending until the MDU write is accepted
    vecs[8]  = mk(3'b000, 15'd0, 96'd0, 1, 9, 0, 9, 0, 3'b000, 0, 0);
    vecs[9]  = mk(3'b000, 15'd0, 96'd0, 0, 0, 0, 9, 0, 3'b000, 1, 0);
    vecs[10] = mk(3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 64'h0}, 0, 0, 0, 9, 0, 3'b100, 1, 0);
    vecs[11] = mk(3'b000, 15'd0, 96'd0, 0, 0, 0, 9, 0, 3'b000, 0, 0);
    // set and clear of x4 on one edge, then flush beating a set
    vecs[12] = mk(3'b000, 15'd0, 96'd0, 1, 4, 0, 0, 4, 3'b000, 0, 0);
    vecs[13] = mk(3'b001, {10'd0, 5'd4}, {64'h0, 32'h44}, 1, 4, 0, 0, 4, 3'b001, 0, 1);
    vecs[14] = mk(3'b000, 15'd0, 96'd0, 0, 0, 0, 0, 4, 3'b000, 0, 1);
    vecs[15] = mk(3'b000, 15'd0, 96'd0, 1, 10, 1, 10, 4, 3'b000, 0, 1);
    vecs[16] = mk(3'b000, 15'd0, 96'd0, 0, 0, 0, 10, 4, 3'b000, 0, 0);
    // ALU and MDU both to x12: serialised in grant order
    vecs[17] = mk(3'b101, {5'd12, 5'd0, 5'd12}, {32'h222, 32'h0, 32'h111}, 0, 0, 0, 0, 0, 3'b100, 0, 0);
    vecs[18] = mk(3'b101, {5'd12, 5'd0, 5'd12}, {32'h222, 32'h0, 32'h111}, 0, 0, 0, 0, 0, 3'b001, 0, 0);

    rst = 1'b1;
    drive(mk(3'b111, A567, DABC, 0, 0, 0, 0, 0, 3'b000, 0, 0));
    @(posedge clk); #1;
    chk("rst we", 64'(we), 64'(0));
    chk("rst waddr", 64'(waddr), 64'(0));
    chk("rst wdata", 64'(wdata), 64'(0));
    #4;
    chk("rst ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    m_out = '0;

    for (int n = 0; n < 19; n++) step(vecs[n], $sformatf("v%0d", n));

    // rr is 1 here; grant x8 and mark it pending, then reset mid-operation
    step(mk(3'b001, {10'd0, 5'd8}, {64'h0, 32'h88}, 1, 8, 0, 8, 0, 3'b001, 0, 0), "x8");
    rst = 1'b1;
    #4;
    chk("midrst ready", 64'(req_ready), 64'(0));
    chk("midrst busy_a", 64'(busy_a), 64'(0));
    @(posedge clk); #1;
    chk("midrst we", 64'(we), 64'(0));
    chk("midrst waddr", 64'(waddr), 64'(0));
    chk("midrst wdata", 64'(wdata), 64'(0));
    rst = 1'b0;
    m_out = '0;
    sbq.delete();
    // rr must be back at 0 and pending[8] gone
    step(mk(3'b111, A567, DABC, 0, 0, 0, 8, 0, 3'b001, 0, 0), "postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back arbiter and scoreboard for the single-write-port integer register file. It shares the one write port between NUM_REQ write-back sources (ALU, LSU, MDU) using a valid/ready handshake and round-robin priority. It drives the register-file write port from a register stage. It also keeps a per-register pending scoreboard that the decode stage uses for RAW hazard checks. The block sits between the execute units and the register file.

Parameters:
NUM_REQ, 3, number of write-back requesters (index 0 = ALU, 1 = LSU, 2 = MDU); legal range 2..8
DATA_W, 32, write data width

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous reset, active-high
req_valid_i  input  NUM_REQ  per-source write-back request
req_addr_i  input  NUM_REQ*5  per-source destination register; source k in bits [5k+4:5k]
req_data_i  input  NUM_REQ*DATA_W  per-source write data; source k in slice k
req_ready_o  output  NUM_REQ  per-source grant; a request is accepted when valid and ready are both 1
we_o  output  1  register-file write enable
waddr_o  output  5  register-file write address
wdata_o  output  DATA_W  register-file write data
set_valid_i  input  1  decode issues an instruction that will write set_addr_i
set_addr_i  input  5  destination to mark pending
flush_i  input  1  pipeline flush; clears the scoreboard
raddr_a_i  input  5  decode read address A
raddr_b_i  input  5  decode read address B
busy_a_o  output  1  register raddr_a_i is pending
busy_b_o  output  1  register raddr_b_i is pending

Behaviour:
- Reset (rst_i=1 at an edge):
  - we_o=0, waddr_o=0, wdata_o=0.
  - Round-robin pointer rr=0.
  - All pending bits = 0.
  - While rst_i=1, req_ready_o is all 0 and busy_a_o/busy_b_o are 0.
  - A reset asserted mid-operation discards any accepted-but-unwritten entry: we_o is 0 in the cycle after the reset edge.
- Arbitration (combinational):
  - Search sources from rr upward, wrapping modulo NUM_REQ.
  - The first source with req_valid_i=1 is granted: its req_ready_o=1; all others 0.
  - Granting at most one source per cycle is a hard requirement.
  - If no source is valid, all ready outputs are 0.
  - req_ready_o may depend combinationally on req_valid_i.
  - Requesters must hold valid, addr and data stable until accepted.
- Pointer update:
  - On an accepted handshake by source g, rr <= (g+1) mod NUM_REQ.
  - With no handshake, rr is unchanged.
  - Any continuously valid source is granted within NUM_REQ cycles.
- Output stage (latency 1):
  - On the edge that accepts source g: waddr_o <= addr_g, wdata_o <= data_g, we_o <= (addr_g != 0).
  - With no accept: we_o <= 0; waddr_o and wdata_o hold their previous values.
  - A write to x0 completes the handshake but never asserts we_o.
- Scoreboard (32-bit pending vector, bit 0 hardwired 0):
  - Set: set_valid_i=1 with set_addr_i!=0 sets pending[set_addr_i] at the edge.
  - Clear: an accepted request to register r clears pending[r] on the same edge that loads the output stage. In the cycle where we_o=1, the register is therefore already not busy, and the register file's same-cycle write bypass supplies the data.
  - Set and clear of the same register on the same edge: set wins (newer producer).
  - flush_i=1 clears all pending bits at the edge and overrides any set or clear on that edge. Flush does not affect arbitration or the output stage.
- Busy outputs (combinational):
  - busy_a_o = pending[raddr_a_i]; busy_b_o = pending[raddr_b_i].
  - Both are 0 for address 0.
- Multiple requesters targeting the same register are serialised in grant order; the last write wins in the register file.

Test Plan:
- Reset release, all three sources valid (addrs 5/6/7, data 0xA/0xB/0xC) held continuously -> grants in order 0,1,2,0,… one per cycle; we_o=1 one cycle after each grant with waddr_o=5,6,7 and matching data.
- Only LSU valid (addr 3, data 0xDEADBEEF) with rr=0 -> req_ready_o=3'b010 the same cycle; next cycle we_o=1, waddr_o=3, wdata_o=0xDEADBEEF; rr=2.
- ALU request to x0 with data 0x1234 -> ready=1, handshake completes; following cycle we_o=0; no pending bit changes.
- set_valid_i with set_addr_i=9, then raddr_a_i=9 -> busy_a_o=1 until the MDU write to x9 is accepted; in the we_o=1 cycle busy_a_o=0.
- Same edge: ALU accepted to x4 (pending[4]=1) and set_valid_i with set_addr_i=4 -> pending[4] remains 1. A separate edge with set_valid_i and flush_i both 1 -> all pending bits 0.
- rst_i asserted the cycle after a grant to x8 -> the next cycle has we_o=0, waddr_o=0, wdata_o=0, busy outputs 0, rr=0.
